// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: 1 Hz tick prescaler, button debounce and RUN/SET_HOUR/SET_MIN
// sequencer that edits shadow hour/minute and loads them into the time datapath.
`default_nettype none

module clock_set_ctrl #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int BLINK_CYCLES    = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch,
  input  logic       btn_inc,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic       tick,
  output logic       run_en,
  output logic       load,
  output logic [4:0] load_hour,
  output logic [5:0] load_min,
  output logic [5:0] load_sec,
  output logic [1:0] mode,
  output logic       blank_hour,
  output logic       blank_min
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HOUR = 2'd1,
    S_MIN  = 2'd2
  } state_t;

  logic [1:0] btn_raw;
  logic [1:0] press;
  assign btn_raw = {btn_inc, switch};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic            sync1_q, sync2_q, db_q, db_dly_q;
    logic [DB_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        db_q     <= 1'b0;
        db_dly_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q  <= btn_raw[b];
        sync2_q  <= sync1_q;
        db_dly_q <= db_q;
        if (sync2_q == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_q  <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + DB_W'(1);
        end
      end
    end

    assign press[b] = db_q & ~db_dly_q;
  end

  logic            mode_press, inc_press, inc_hit;
  state_t          state_q, state_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [BL_W-1:0] blink_q, blink_d;
  logic            phase_q, phase_d;
  logic            tick_q, tick_d, load_q, load_d;
  logic            run_en_q, blank_hour_q, blank_min_q;

  assign mode_press = press[0];
  assign inc_press  = press[1];

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    load_d  = 1'b0;
    inc_hit = 1'b0;
    tick_d  = 1'b0;
    ps_d    = '0;
    blink_d = '0;
    phase_d = 1'b0;

    // Mode press has priority; a coincident inc press is dropped.
    case (state_q)
      S_RUN: begin
        if (mode_press) begin
          state_d = S_HOUR;
          hour_d  = cur_hour;
          min_d   = cur_min;
        end
      end
      S_HOUR: begin
        if (mode_press) begin
          state_d = S_MIN;
        end else if (inc_press) begin
          hour_d  = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          inc_hit = 1'b1;
        end
      end
      S_MIN: begin
        if (mode_press) begin
          state_d = S_RUN;
          load_d  = 1'b1;
        end else if (inc_press) begin
          min_d   = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          inc_hit = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase

    // Prescaler only runs while staying in RUN, so it restarts from 0 after a load.
    if (state_q == S_RUN && state_d == S_RUN) begin
      if (ps_q == PS_W'(CLK_HZ - 1)) begin
        tick_d = 1'b1;
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end

    if (state_d != S_RUN && state_d == state_q && !inc_hit) begin
      if (blink_q == BL_W'(BLINK_CYCLES - 1)) begin
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BL_W'(1);
        phase_d = phase_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_RUN;
      hour_q       <= '0;
      min_q        <= '0;
      ps_q         <= '0;
      blink_q      <= '0;
      phase_q      <= 1'b0;
      tick_q       <= 1'b0;
      load_q       <= 1'b0;
      run_en_q     <= 1'b1;
      blank_hour_q <= 1'b0;
      blank_min_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      ps_q         <= ps_d;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      tick_q       <= tick_d;
      load_q       <= load_d;
      run_en_q     <= (state_d == S_RUN);
      blank_hour_q <= (state_d == S_HOUR) & phase_d;
      blank_min_q  <= (state_d == S_MIN) & phase_d;
    end
  end

  assign tick       = tick_q;
  assign run_en     = run_en_q;
  assign load       = load_q;
  assign load_hour  = hour_q;
  assign load_min   = min_q;
  assign load_sec   = 6'd0;
  assign mode       = state_q;
  assign blank_hour = blank_hour_q;
  assign blank_min  = blank_min_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: table vectors, corner-case sequences,
// and random button presses checked against a modulo-arithmetic reference model.
`default_nettype none

module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       switch = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0;
  logic       tick, run_en, load, blank_hour, blank_min;
  logic [4:0] load_hour;
  logic [5:0] load_min, load_sec;
  logic [1:0] mode;

  clock_set_ctrl #(.CLK_HZ(10), .DEBOUNCE_CYCLES(4), .BLINK_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .switch(switch), .btn_inc(btn_inc),
    .cur_hour(cur_hour), .cur_min(cur_min), .tick(tick), .run_en(run_en),
    .load(load), .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
    .mode(mode), .blank_hour(blank_hour), .blank_min(blank_min)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_load, n_tick, load_cyc;
  bit tick_bad;
  logic [31:0] ld_h, ld_m, ld_s;

  typedef struct {
    bit is_mode;
    int ch;
    int cm;
    int e_mode;
    int e_hour;
    int e_min;
    int e_loads;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold the chosen buttons for hi cycles then release for lo cycles, logging load/tick.
  task automatic press(input bit do_mode, input bit do_inc, input int hi, input int lo);
    switch   = do_mode;
    btn_inc  = do_inc;
    n_load   = 0;
    n_tick   = 0;
    tick_bad = 1'b0;
    load_cyc = -1;
    for (int i = 0; i < hi + lo; i++) begin
      if (i == hi) begin
        switch  = 1'b0;
        btn_inc = 1'b0;
      end
      step();
      if (load === 1'b1) begin
        n_load++;
        ld_h = 32'(load_hour);
        ld_m = 32'(load_min);
        ld_s = 32'(load_sec);
        load_cyc = cyc;
      end
      if (tick === 1'b1) begin
        n_tick++;
        if (load_cyc < 0 || cyc != load_cyc + 10) tick_bad = 1'b1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev_mode, mst, mh, mm, ch, cm, pick, exp_load, bad, k;
    bit do_mode;

    tbl[0] = '{1, 23, 59, 1, 23, 59, 0};
    tbl[1] = '{0, 23, 59, 1,  0, 59, 0};
    tbl[2] = '{1, 23, 59, 2,  0, 59, 0};
    tbl[3] = '{0, 23, 59, 2,  0,  0, 0};
    tbl[4] = '{0, 23, 59, 2,  0,  1, 0};
    tbl[5] = '{1, 23, 59, 0,  0,  1, 1};

    // Reset state
    step();
    step();
    chk("rst_tick", tick, 0);
    chk("rst_load", load, 0);
    chk("rst_mode", mode, 0);
    chk("rst_run_en", run_en, 1);
    chk("rst_blank", {blank_hour, blank_min}, 0);
    chk("rst_shadow", {load_hour, load_min, load_sec}, 0);

    // Tick cadence from reset release
    reset = 1'b1;
    bad = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("tick_period", tick, (i % 10 == 0) ? 1 : 0);
      if (run_en !== 1'b1 || mode !== 2'd0 || load !== 1'b0) bad++;
    end
    chk("run_outputs", bad, 0);

    // Full edit sequence from a table, with wrap at 23 and 59
    prev_mode = 0;
    for (int i = 0; i < 6; i++) begin
      cur_hour = 5'(tbl[i].ch);
      cur_min  = 6'(tbl[i].cm);
      press(tbl[i].is_mode, !tbl[i].is_mode, 8, 14);
      chk("tbl_mode", mode, tbl[i].e_mode);
      chk("tbl_hour", load_hour, tbl[i].e_hour);
      chk("tbl_min", load_min, tbl[i].e_min);
      chk("tbl_loads", n_load, tbl[i].e_loads);
      if (tbl[i].e_loads == 1) begin
        chk("tbl_ld_hour", ld_h, tbl[i].e_hour);
        chk("tbl_ld_min", ld_m, tbl[i].e_min);
        chk("tbl_ld_sec", ld_s, 0);
      end
      if (prev_mode != 0) begin
        chk("tbl_tick_count", n_tick, tbl[i].e_loads);
        chk("tbl_tick_timing", tick_bad, 0);
      end
      prev_mode = tbl[i].e_mode;
    end

    // Short glitch ignored, full press counted once, release silent
    cur_hour = 5'd5;
    cur_min  = 6'd7;
    press(1, 0, 8, 14);
    chk("enter_hour_mode", mode, 1);
    chk("enter_hour_val", load_hour, 5);
    press(0, 1, 3, 14);
    chk("short_inc", load_hour, 5);
    press(0, 1, 8, 14);
    chk("long_inc", load_hour, 6);
    chk("long_inc_mode", mode, 1);

    // Simultaneous mode and inc: mode wins
    press(1, 1, 8, 14);
    chk("simul_mode", mode, 2);
    chk("simul_hour", load_hour, 6);
    chk("simul_min", load_min, 7);

    // Reset mid-SET discards edits with no load
    press(0, 1, 8, 14);
    chk("set_min_inc", load_min, 8);
    reset = 1'b0;
    #1;
    chk("midrst_mode", mode, 0);
    chk("midrst_shadow", {load_hour, load_min}, 0);
    chk("midrst_blank", {blank_hour, blank_min}, 0);
    chk("midrst_run_en", run_en, 1);
    chk("midrst_load", load, 0);
    step();
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (load === 1'b1) k++;
    end
    chk("midrst_no_load", k, 0);
    chk("midrst_mode_after", mode, 0);

    // Blink phase in SET_HOUR, restart on inc press
    cur_hour = 5'd3;
    switch = 1'b1;
    k = 0;
    while (mode !== 2'd1 && k < 20) begin
      step();
      k++;
    end
    chk("blink_enter_timeout", (mode === 2'd1) ? 1 : 0, 1);
    switch = 1'b0;
    chk("blink_k0", blank_hour, 0);
    bad = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("blink_hour", blank_hour, (i / 3) % 2);
      if (blank_min !== 1'b0) bad++;
    end
    chk("blink_min_quiet", bad, 0);
    btn_inc = 1'b1;
    k = 0;
    while (load_hour !== 5'd4 && k < 20) begin
      step();
      k++;
    end
    chk("blink_inc_timeout", load_hour, 4);
    chk("blink_inc_clear", blank_hour, 0);
    btn_inc = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("blink_restart", blank_hour, (i / 3) % 2);
    end

    // Random presses against a modulo-arithmetic model
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    mst = 0;
    mh  = 0;
    mm  = 0;
    for (int i = 0; i < 30; i++) begin
      ch = int'($urandom_range(0, 23));
      cm = int'($urandom_range(0, 59));
      pick = int'($urandom_range(0, 2));
      do_mode = (pick == 0);
      cur_hour = 5'(ch);
      cur_min  = 6'(cm);
      prev_mode = mst;
      exp_load = 0;
      if (do_mode) begin
        if (mst == 0) begin
          mst = 1;
          mh = ch;
          mm = cm;
        end else if (mst == 1) begin
          mst = 2;
        end else begin
          mst = 0;
          exp_load = 1;
        end
      end else if (mst == 1) begin
        mh = (mh + 1) % 24;
      end else if (mst == 2) begin
        mm = (mm + 1) % 60;
      end
      press(do_mode, !do_mode, 8, 14);
      chk("rnd_mode", mode, mst);
      chk("rnd_run_en", run_en, (mst == 0) ? 1 : 0);
      chk("rnd_hour", load_hour, mh);
      chk("rnd_min", load_min, mm);
      chk("rnd_loads", n_load, exp_load);
      if (exp_load == 1) begin
        chk("rnd_ld_hour", ld_h, mh);
        chk("rnd_ld_min", ld_m, mm);
        chk("rnd_ld_sec", ld_s, 0);
      end
      if (prev_mode != 0) begin
        chk("rnd_tick_count", n_tick, exp_load);
        chk("rnd_tick_timing", tick_bad, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
